// File: rtl/uart_tx_packetizer.sv
// FIFO-buffered framer feeding a uart_tx: emits HEADER, the payload bytes and, when
// UART_PKT_CHECKSUM_EN is defined, a trailing XOR checksum byte.
module uart_tx_packetizer #(
    parameter int unsigned       BITS_N = 8,
    parameter int unsigned       DEPTH  = 16,
    parameter logic [BITS_N-1:0] HEADER = 8'hAA
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [BITS_N-1:0]      in_data,
    input  logic                   in_last,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [BITS_N-1:0]      tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   frame_done
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHdr     = 2'd1,
        StPayload = 2'd2
`ifdef UART_PKT_CHECKSUM_EN
        , StCsum  = 2'd3
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic [BITS_N:0]   mem_q [DEPTH];
`ifdef UART_PKT_CHECKSUM_EN
    logic [BITS_N-1:0] csum_q, csum_d;
`endif

    logic              full, empty, push, pop, tx_fire, head_last;
    logic [BITS_N-1:0] head_data;

    assign full       = (count_q == FullCnt);
    assign empty      = (count_q == '0);
    assign in_ready   = !full;
    assign push       = in_valid && in_ready;
    assign tx_fire    = tx_valid && tx_ready;
    assign pop        = tx_fire && (state_q == StPayload);
    assign head_last  = mem_q[rd_ptr_q][BITS_N];
    assign head_data  = mem_q[rd_ptr_q][BITS_N-1:0];
    assign fifo_count = count_q;

    // Outputs decode only registered state, so tx_data cannot move while a byte is offered.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = '0;
        case (state_q)
            StHdr: begin
                tx_valid = 1'b1;
                tx_data  = HEADER;
            end
            StPayload: begin
                tx_valid = !empty;
                tx_data  = head_data;
            end
`ifdef UART_PKT_CHECKSUM_EN
            StCsum: begin
                tx_valid = 1'b1;
                tx_data  = csum_q;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
`ifdef UART_PKT_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            StIdle: begin
                if (!empty) state_d = StHdr;
            end
            StHdr: begin
                if (tx_fire) begin
                    state_d = StPayload;
`ifdef UART_PKT_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            StPayload: begin
                if (tx_fire) begin
`ifdef UART_PKT_CHECKSUM_EN
                    csum_d = csum_q ^ head_data;
                    if (head_last) state_d = StCsum;
`else
                    if (head_last) begin
                        state_d    = StIdle;
                        frame_done = 1'b1;
                    end
`endif
                end
            end
`ifdef UART_PKT_CHECKSUM_EN
            StCsum: begin
                if (tx_fire) begin
                    state_d    = StIdle;
                    frame_done = 1'b1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Storage is not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_last, in_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef UART_PKT_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifdef UART_PKT_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

endmodule
